// File: rtl/mips32_divider.sv
// mips32_divider: multi-cycle radix-2 restoring DIV/DIVU unit with fixed latency.
module mips32_divider #(
  parameter int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk1,
  input  logic             rst,
  input  logic             start,
  input  logic             flush,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, FIX} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
  logic [WIDTH-1:0] q_q, q_d, r_q, r_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic sg_q, sg_d, sa_q, sa_d, sb_q, sb_d, dz_q, dz_d, done_q, done_d;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH+1:0] diff;
  logic ge;
  assign rem_sh = {rem_q, quo_q[WIDTH-1]};
  assign diff = {1'b0, rem_sh} - {2'b00, dvs_q};
  assign ge = ~diff[WIDTH+1];
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    sg_d = sg_q;
    sa_d = sa_q;
    sb_d = sb_q;
    quo_d = quo_q;
    rem_d = rem_q;
    dvs_d = dvs_q;
    cnt_d = cnt_q;
    q_d = q_q;
    r_d = r_q;
    dz_d = dz_q;
    done_d = 1'b0;
    if (flush) state_d = IDLE;
    else
      case (state_q)
        IDLE: if (start) begin
          state_d = LOAD;
          a_d = dividend;
          b_d = divisor;
          sg_d = is_signed;
        end
        LOAD: begin
          sa_d = sg_q & a_q[WIDTH-1];
          sb_d = sg_q & b_q[WIDTH-1];
          quo_d = (sg_q & a_q[WIDTH-1]) ? -a_q : a_q;
          dvs_d = (sg_q & b_q[WIDTH-1]) ? -b_q : b_q;
          rem_d = '0;
          cnt_d = CNT_W'(WIDTH);
          state_d = RUN;
        end
        RUN: begin
          rem_d = ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], ge};
          cnt_d = cnt_q - CNT_W'(1);
          state_d = (cnt_q == CNT_W'(1)) ? FIX : RUN;
        end
        default: begin
          // A zero divisor reports the original dividend, not the sign-fixed magnitude.
          dz_d = (b_q == '0);
          q_d = dz_d ? '1 : ((sa_q ^ sb_q) ? -quo_q : quo_q);
          r_d = dz_d ? a_q : (sa_q ? -rem_q : rem_q);
          done_d = 1'b1;
          state_d = IDLE;
        end
      endcase
  end
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      sg_q <= 1'b0;
      sa_q <= 1'b0;
      sb_q <= 1'b0;
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
      q_q <= '0;
      r_q <= '0;
      dz_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      sg_q <= sg_d;
      sa_q <= sa_d;
      sb_q <= sb_d;
      quo_q <= quo_d;
      rem_q <= rem_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
      q_q <= q_d;
      r_q <= r_d;
      dz_q <= dz_d;
      done_q <= done_d;
    end
  end
  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign div_zero = dz_q;
  assign quotient = q_q;
  assign remainder = r_q;
endmodule

// File: tb/tb_mips32_divider.sv
// tb_mips32_divider: directed checks of a 32-bit and an 8-bit divider instance.
module tb_mips32_divider;
  logic clk1 = 1'b0, rst = 1'b1, flush = 1'b0;
  logic st32 = 1'b0, sg32 = 1'b0, st8 = 1'b0, sg8 = 1'b0;
  logic [31:0] dv32 = '0, ds32 = '0, q32, r32;
  logic [7:0] dv8 = '0, ds8 = '0, q8, r8;
  logic busy32, done32, dz32, busy8, done8, dz8;
  int pass_cnt = 0, total = 0;

  always #5 clk1 = ~clk1;

  mips32_divider #(.WIDTH(32)) u32 (.clk1(clk1), .rst(rst), .start(st32), .flush(flush),
    .is_signed(sg32), .dividend(dv32), .divisor(ds32), .busy(busy32), .done(done32),
    .div_zero(dz32), .quotient(q32), .remainder(r32));
  mips32_divider #(.WIDTH(8)) u8 (.clk1(clk1), .rst(rst), .start(st8), .flush(flush),
    .is_signed(sg8), .dividend(dv8), .divisor(ds8), .busy(busy8), .done(done8),
    .div_zero(dz8), .quotient(q8), .remainder(r8));

  // Drives start now, returns the edge count to done (-1 on timeout) and busy cycles seen before it.
  task automatic issue32(input logic [31:0] a, input logic [31:0] b, input logic sg,
                         output int lat, output int bcnt);
    dv32 = a; ds32 = b; sg32 = sg; st32 = 1'b1;
    @(posedge clk1); #1 st32 = 1'b0;
    lat = -1; bcnt = 0;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk1); #1;
      if (done32) begin lat = n; break; end
      if (busy32) bcnt++;
    end
  endtask

  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic sg, output int lat);
    dv8 = a; ds8 = b; sg8 = sg; st8 = 1'b1;
    @(posedge clk1); #1 st8 = 1'b0;
    lat = -1;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk1); #1;
      if (done8) begin lat = n; break; end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk1);
    #1;
    total++; if ({busy32, done32, dz32} !== 3'b000) $display("FAIL reset_flags32 got %b exp 000", {busy32, done32, dz32}); else pass_cnt++;
    total++; if ({q32, r32} !== 64'd0) $display("FAIL reset_qr32 got %h exp 0", {q32, r32}); else pass_cnt++;
    total++; if ({busy8, done8, dz8, q8, r8} !== 19'd0) $display("FAIL reset_8 got %h exp 0", {busy8, done8, dz8, q8, r8}); else pass_cnt++;
    rst = 1'b0;
    @(posedge clk1); #1;
  endtask

  task automatic test_unsigned;
    int lat, bcnt;
    issue32(32'd23, 32'd5, 1'b0, lat, bcnt);
    total++; if (lat !== 34) $display("FAIL u_latency got %0d exp 34", lat); else pass_cnt++;
    total++; if (bcnt !== 33) $display("FAIL u_busy_cycles got %0d exp 33", bcnt); else pass_cnt++;
    total++; if (busy32 !== 1'b0) $display("FAIL u_busy_at_done got %b exp 0", busy32); else pass_cnt++;
    total++; if ({q32, r32, dz32} !== {32'd4, 32'd3, 1'b0}) $display("FAIL u_23_5 got q=%h r=%h dz=%b exp 4 3 0", q32, r32, dz32); else pass_cnt++;
    @(posedge clk1); #1;
    total++; if (done32 !== 1'b0) $display("FAIL u_done_pulse got %b exp 0", done32); else pass_cnt++;
    issue32(32'hFFFFFFE9, 32'd5, 1'b0, lat, bcnt);
    total++; if ({q32, r32} !== {32'h3333332E, 32'd3}) $display("FAIL u_msb_data got q=%h r=%h exp 3333332e 3", q32, r32); else pass_cnt++;
  endtask

  task automatic test_signed;
    logic [31:0] a[3] = '{32'hFFFFFFE9, 32'd23, 32'hFFFFFFE9};
    logic [31:0] b[3] = '{32'd5, 32'hFFFFFFFB, 32'hFFFFFFFB};
    logic [31:0] eq[3] = '{32'hFFFFFFFC, 32'hFFFFFFFC, 32'd4};
    logic [31:0] er[3] = '{32'hFFFFFFFD, 32'd3, 32'hFFFFFFFD};
    int lat, bcnt;
    for (int i = 0; i < 3; i++) begin
      issue32(a[i], b[i], 1'b1, lat, bcnt);
      total++; if ({q32, r32} !== {eq[i], er[i]} || lat !== 34) $display("FAIL signed_%0d got q=%h r=%h lat=%0d exp q=%h r=%h lat=34", i, q32, r32, lat, eq[i], er[i]); else pass_cnt++;
    end
  endtask

  task automatic test_div_zero;
    int lat, bcnt;
    issue32(32'd100, 32'd0, 1'b0, lat, bcnt);
    total++; if ({q32, r32, dz32} !== {32'hFFFFFFFF, 32'd100, 1'b1} || lat !== 34) $display("FAIL dz_100_0 got q=%h r=%h dz=%b lat=%0d exp ffffffff 64 1 34", q32, r32, dz32, lat); else pass_cnt++;
    issue32(32'd9, 32'd3, 1'b0, lat, bcnt);
    total++; if ({q32, r32, dz32} !== {32'd3, 32'd0, 1'b0}) $display("FAIL dz_clear got q=%h r=%h dz=%b exp 3 0 0", q32, r32, dz32); else pass_cnt++;
    issue32(32'hFFFFFFE9, 32'd0, 1'b1, lat, bcnt);
    total++; if ({q32, r32, dz32} !== {32'hFFFFFFFF, 32'hFFFFFFE9, 1'b1}) $display("FAIL dz_signed got q=%h r=%h dz=%b exp ffffffff ffffffe9 1", q32, r32, dz32); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    int lat, bcnt;
    issue32(32'h80000000, 32'hFFFFFFFF, 1'b1, lat, bcnt);
    total++; if ({q32, r32, dz32} !== {32'h80000000, 32'd0, 1'b0}) $display("FAIL overflow got q=%h r=%h dz=%b exp 80000000 0 0", q32, r32, dz32); else pass_cnt++;
    issue32(32'hFFFFFFFF, 32'd1, 1'b0, lat, bcnt);
    total++; if (lat !== 34) $display("FAIL b2b_latency got %0d exp 34", lat); else pass_cnt++;
    total++; if ({q32, r32} !== {32'hFFFFFFFF, 32'd0}) $display("FAIL b2b_result got q=%h r=%h exp ffffffff 0", q32, r32); else pass_cnt++;
  endtask

  task automatic test_start_busy;
    int ndone = 0, first = -1;
    dv32 = 32'd23; ds32 = 32'd5; sg32 = 1'b0; st32 = 1'b1;
    @(posedge clk1); #1 st32 = 1'b0;
    for (int n = 1; n <= 45; n++) begin
      @(posedge clk1); #1;
      if (n == 10) begin dv32 = 32'd7; ds32 = 32'd7; st32 = 1'b1; end
      if (n == 11) st32 = 1'b0;
      if (done32) begin ndone++; if (first < 0) first = n; end
    end
    total++; if (ndone !== 1 || first !== 34) $display("FAIL busy_start_done got n=%0d at=%0d exp 1 at 34", ndone, first); else pass_cnt++;
    total++; if ({q32, r32} !== {32'd4, 32'd3}) $display("FAIL busy_start_result got q=%h r=%h exp 4 3", q32, r32); else pass_cnt++;
  endtask

  task automatic test_flush;
    int ndone = 0;
    dv32 = 32'd100; ds32 = 32'd9; sg32 = 1'b0; st32 = 1'b1;
    @(posedge clk1); #1 st32 = 1'b0;
    repeat (15) @(posedge clk1);
    #1 flush = 1'b1;
    @(posedge clk1); #1 flush = 1'b0;
    total++; if ({busy32, done32} !== 2'b00) $display("FAIL flush_idle got busy=%b done=%b exp 0 0", busy32, done32); else pass_cnt++;
    for (int n = 0; n < 30; n++) begin
      @(posedge clk1); #1;
      if (done32) ndone++;
    end
    total++; if (ndone !== 0) $display("FAIL flush_no_done got %0d exp 0", ndone); else pass_cnt++;
    total++; if ({q32, r32, dz32} !== {32'd4, 32'd3, 1'b0}) $display("FAIL flush_hold got q=%h r=%h dz=%b exp 4 3 0", q32, r32, dz32); else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    int ndone = 0;
    dv32 = 32'd23; ds32 = 32'd5; sg32 = 1'b0; st32 = 1'b1;
    @(posedge clk1); #1 st32 = 1'b0;
    repeat (10) @(posedge clk1);
    #3 rst = 1'b1;
    #1;
    total++; if ({busy32, done32, dz32, q32, r32} !== 67'd0) $display("FAIL rst_mid got busy=%b done=%b q=%h r=%h exp all 0", busy32, done32, q32, r32); else pass_cnt++;
    #1 rst = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk1); #1;
      if (done32 || busy32) ndone++;
    end
    total++; if (ndone !== 0) $display("FAIL rst_mid_quiet got %0d exp 0", ndone); else pass_cnt++;
  endtask

  task automatic test_width8;
    int lat;
    issue8(8'd200, 8'd7, 1'b0, lat);
    total++; if (lat !== 10) $display("FAIL w8_latency got %0d exp 10", lat); else pass_cnt++;
    total++; if ({q8, r8, dz8} !== {8'd28, 8'd4, 1'b0}) $display("FAIL w8_200_7 got q=%h r=%h dz=%b exp 1c 04 0", q8, r8, dz8); else pass_cnt++;
    issue8(8'h80, 8'hFF, 1'b1, lat);
    total++; if ({q8, r8} !== {8'h80, 8'h00}) $display("FAIL w8_overflow got q=%h r=%h exp 80 00", q8, r8); else pass_cnt++;
    issue8(8'd200, 8'd0, 1'b0, lat);
    total++; if ({q8, r8, dz8} !== {8'hFF, 8'd200, 1'b1} || lat !== 10) $display("FAIL w8_dz got q=%h r=%h dz=%b lat=%0d exp ff c8 1 10", q8, r8, dz8, lat); else pass_cnt++;
  endtask

  initial begin
    test_reset;
    test_unsigned;
    test_signed;
    test_div_zero;
    test_back_to_back;
    test_start_busy;
    test_flush;
    test_reset_mid;
    test_width8;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
